stream_demux_1xn: RTL and testbench



---
 rtl/stream_demux_1xn.sv | 121 ++++++++++++
 tb/tb_stream_demux_1xn.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: parametrised 1-to-N valid/ready stream demultiplexer.
// Each output channel owns a one-entry registered holding stage, so a stall
// on one channel never blocks beats headed to the others.
// Optional per-channel delivered-beat counters: define STREAM_DEMUX_CNT_EN.
// Without the macro the cnt port is tied to zero and no counter flops exist.

// One output channel: holding register plus optional delivered-beat counter.
module stream_demux_1xn_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [15:0]      cnt
);

  // Holding slot: a load wins over a drain so drain-and-load keeps full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt_q;

  // Count beats handed downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (valid & ready)
      cnt_q <= cnt_q + 16'd1;
  end

  assign cnt = cnt_q;
`else
  assign cnt = 16'd0;
`endif

endmodule

// Top: select decode, input handshake, out-of-range error pulse.
module stream_demux_1xn #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SW    = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic [SW-1:0]      s_sel,
  output logic [N-1:0]       m_valid,
  input  logic [N-1:0]       m_ready,
  output logic [N*WIDTH-1:0] m_data,
  output logic               sel_err,
  output logic [N*16-1:0]    cnt
);

  // One extra bit so the range compare also works when N == 2**SW.
  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  logic                        in_range;
  logic                        accept;
  logic [N-1:0]                load;
  logic [N-1:0][WIDTH-1:0]     data_arr;
  logic [N-1:0][15:0]          cnt_arr;

  assign in_range = ({1'b0, s_sel} < N_EXT);

  // Ready looks only at the selected slot; out-of-range beats are always taken.
  always_comb begin
    s_ready = 1'b1;
    for (int k = 0; k < N; k++)
      if (s_sel == SW'(k))
        s_ready = ~m_valid[k] | m_ready[k];
  end

  assign accept = s_valid & s_ready & ~rst;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_chan
      assign load[g] = accept & (s_sel == SW'(g));

      stream_demux_1xn_chan #(.WIDTH(WIDTH)) u_chan (
        .clk       (clk),
        .rst       (rst),
        .load      (load[g]),
        .load_data (s_data),
        .ready     (m_ready[g]),
        .valid     (m_valid[g]),
        .data      (data_arr[g]),
        .cnt       (cnt_arr[g])
      );
    end
  endgenerate

  assign m_data = data_arr;
  assign cnt    = cnt_arr;

  // Pulse for exactly one cycle after a dropped out-of-range beat.
  always_ff @(posedge clk) begin
    if (rst)
      sel_err <= 1'b0;
    else
      sel_err <= accept & ~in_range;
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: N=4 instance checked every cycle against a
// behavioural slot model, plus an N=3 instance for the out-of-range select.
module tb_stream_demux_1xn;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [1:0]  s_sel;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic        sel_err;
  logic [63:0] cnt;

  logic        v3;
  logic        rdy3_s;
  logic [7:0]  d3;
  logic [1:0]  sel3;
  logic [2:0]  mv3;
  logic [2:0]  mr3;
  logic [23:0] md3;
  logic        err3;
  logic [47:0] cnt3;

  int total = 0;
  int bad   = 0;
  bit go    = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.N(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sel(s_sel), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .sel_err(sel_err), .cnt(cnt));

  stream_demux_1xn #(.N(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(v3), .s_ready(rdy3_s),
    .s_data(d3), .s_sel(sel3), .m_valid(mv3), .m_ready(mr3),
    .m_data(md3), .sel_err(err3), .cnt(cnt3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model: each channel is a one-deep slot (occupied flag + payload).
  logic [3:0]  ev = '0;
  logic [7:0]  ed [4] = '{default: 8'h00};
  logic [15:0] ec [4] = '{default: 16'h0000};
  logic        eerr = 1'b0;
  logic        exp_ready;

  always_comb begin
    exp_ready = 1'b1;
    if (int'(s_sel) < 4)
      exp_ready = !ev[s_sel] || m_ready[s_sel];
  end

  always @(posedge clk) begin
    if (rst) begin
      ev   <= '0;
      eerr <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        ed[k] <= 8'h00;
        ec[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (ev[k] && m_ready[k]) begin
          ev[k] <= 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
          ec[k] <= ec[k] + 16'd1;
`endif
        end
      if (s_valid && exp_ready && int'(s_sel) < 4) begin
        ev[s_sel] <= 1'b1;
        ed[s_sel] <= s_data;
      end
      eerr <= s_valid && exp_ready && int'(s_sel) >= 4;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (go) begin
      chk("s_ready", {63'd0, s_ready}, {63'd0, exp_ready});
      chk("m_valid", {60'd0, m_valid}, {60'd0, ev});
      chk("m_data",  {32'd0, m_data},  {32'd0, ed[3], ed[2], ed[1], ed[0]});
      chk("sel_err", {63'd0, sel_err}, {63'd0, eerr});
      chk("cnt",     cnt,              {ec[3], ec[2], ec[1], ec[0]});
      chk("cnt3",    {16'd0, cnt3},    64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = d;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sel = '0; m_ready = '0;
    v3 = 1'b0; d3 = '0; sel3 = '0; mr3 = '0;
    @(posedge clk);
    go = 1;
    step();
    chk("rst_m_valid", {60'd0, m_valid}, 64'd0);
    chk("rst_m_data",  {32'd0, m_data},  64'd0);
    chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
    chk("rst_cnt",     cnt,              64'd0);
    rst = 1'b0;

    // 1: streaming through all channels, two beats each
    m_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      send(2'(i / 2), 8'(8'h10 + i));
      #1;
      chk("t1_s_ready", {63'd0, s_ready}, 64'd1);
      step();
      chk("t1_valid", {63'd0, m_valid[i / 2]}, 64'd1);
      chk("t1_data",  {56'd0, m_data[(i / 2) * 8 +: 8]}, {56'd0, 8'(8'h10 + i)});
    end
    s_valid = 1'b0;
    step();
    chk("t1_drained", {60'd0, m_valid}, 64'd0);

    // 2: stall ch2, reroute to ch1, then drain-and-load ch2
    m_ready = 4'b1011;
    send(2'd2, 8'hA0);
    step();
    send(2'd2, 8'hA1);
    #1;
    chk("t2_stall_ready", {63'd0, s_ready}, 64'd0);
    step();
    chk("t2_hold", {56'd0, m_data[23:16]}, 64'hA0);
    send(2'd1, 8'hB0);
    #1;
    chk("t2_reroute_ready", {63'd0, s_ready}, 64'd1);
    step();
    chk("t2_ch1", {55'd0, m_valid[1], m_data[15:8]}, 64'h1B0);
    send(2'd2, 8'hA1);
    m_ready[2] = 1'b1;
    #1;
    chk("t2_drain_ready", {63'd0, s_ready}, 64'd1);
    step();
    chk("t2_ch2_next", {55'd0, m_valid[2], m_data[23:16]}, 64'h1A1);
    s_valid = 1'b0;
    step();

    // 3: drain-and-load on ch0 without a bubble
    m_ready = 4'b1110;
    send(2'd0, 8'h33);
    step();
    m_ready[0] = 1'b1;
    send(2'd0, 8'h55);
    step();
    chk("t3_no_bubble", {55'd0, m_valid[0], m_data[7:0]}, 64'h155);
    s_valid = 1'b0;
    step();
    chk("t3_empty", {63'd0, m_valid[0]}, 64'd0);

    // 4: out-of-range select on the N=3 instance
    v3 = 1'b1; sel3 = 2'b11; d3 = 8'hEE;
    #1;
    chk("t4_ready", {63'd0, rdy3_s}, 64'd1);
    step();
    v3 = 1'b0;
    chk("t4_err", {63'd0, err3}, 64'd1);
    chk("t4_no_valid", {61'd0, mv3}, 64'd0);
    step();
    chk("t4_err_one_cycle", {63'd0, err3}, 64'd0);
    chk("t4_no_valid2", {61'd0, mv3}, 64'd0);

    // 5: reset discards held beats and ignores the beat offered during reset
    m_ready = 4'b0000;
    send(2'd1, 8'h61);
    step();
    send(2'd3, 8'h63);
    step();
    chk("t5_loaded", {60'd0, m_valid}, 64'hA);
    rst = 1'b1;
    send(2'd2, 8'h77);
    step();
    chk("t5_rst_valid", {60'd0, m_valid}, 64'd0);
    chk("t5_rst_data",  {32'd0, m_data},  64'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    step();
    chk("t5_not_delivered", {60'd0, m_valid}, 64'd0);

    // 6: counters (zero throughout unless the feature is built in)
    m_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin send(2'd3, 8'(8'hC0 + i)); step(); end
    for (int i = 0; i < 2; i++) begin send(2'd0, 8'(8'hD0 + i)); step(); end
    s_valid = 1'b0;
    step();
    step();
`ifdef STREAM_DEMUX_CNT_EN
    chk("t6_cnt3", {48'd0, cnt[63:48]}, 64'd5);
    chk("t6_cnt0", {48'd0, cnt[15:0]},  64'd2);
    send(2'd0, 8'h01);
    for (int i = 0; i < 65533; i++) step();
    s_valid = 1'b0;
    step();
    chk("t6_cnt0_max", {48'd0, cnt[15:0]}, 64'hFFFF);
    send(2'd0, 8'h02);
    step();
    s_valid = 1'b0;
    step();
    chk("t6_cnt0_wrap", {48'd0, cnt[15:0]}, 64'd0);
`else
    chk("t6_cnt_off", cnt, 64'd0);
`endif

    // Mixed traffic with stalls to exercise the model on every cycle
    for (int i = 0; i < 24; i++) begin
      m_ready = 4'((i * 5) ^ (i >> 1));
      send(2'(i * 3), 8'(i * 7 + 1));
      s_valid = (i % 4) != 3;
      step();
    end
    s_valid = 1'b0;
    m_ready = 4'hF;
    step();
    step();
    chk("end_idle", {60'd0, m_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
